fifo_sync: RTL and testbench
============================

FIFO_SYNC -- requirements
Module: fifo_sync

Interface
REQ-001 The block SHALL have parameter Depth, default 8, giving the number of entries, which SHALL be a power of two and at least 2.
REQ-002 The block SHALL have parameter Width, default 8, giving the data width in bits.
REQ-003 The block SHALL have parameter AlmostFull, default Depth-2, giving the count at or above which o_almost_full asserts.
REQ-004 The block SHALL have parameter AlmostEmpty, default 2, giving the count at or below which o_almost_empty asserts.
REQ-005 The block SHALL have port i_clk, input, width 1: the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port i_rstn, input, width 1: reset, asynchronous and active-low.
REQ-007 The block SHALL have port i_clr, input, width 1: synchronous flush.
REQ-008 The block SHALL have port i_wr_en, input, width 1: write request.
REQ-009 The block SHALL have port i_wr_data, input, width Width: write data.
REQ-010 The block SHALL have port i_rd_en, input, width 1: read request (pop).
REQ-011 The block SHALL have port o_rd_data, output, width Width: show-ahead head-of-queue data.
REQ-012 The block SHALL have ports o_full, o_empty, o_almost_full and o_almost_empty, each an output of width 1: status flags.
REQ-013 The block SHALL have port o_count, output, width AW+1 (AW = clog2(Depth)): current occupancy, 0..Depth.
REQ-014 The block SHALL have ports o_overflow and o_underflow, each an output of width 1: sticky error flags.

Function
REQ-015 A write SHALL be accepted iff i_wr_en && !o_full; it stores i_wr_data at the write address, which then increments modulo Depth.
REQ-016 A read SHALL be accepted iff i_rd_en && !o_empty; the read address then increments modulo Depth.
REQ-017 o_rd_data SHALL present the entry at the read address combinationally (zero-latency show-ahead); it is undefined while o_empty.
REQ-018 o_count SHALL be registered: +1 on write only, -1 on read only, unchanged on both or neither.
REQ-019 Flag definitions: o_full = (count==Depth), o_empty = (count==0), o_almost_full = (count>=AlmostFull), o_almost_empty = (count<=AlmostEmpty); all flags are decoded from registered state only.
REQ-020 When full with i_wr_en and i_rd_en both high, only the read SHALL be accepted, and the count SHALL drop to Depth-1.
REQ-021 When empty with i_wr_en and i_rd_en both high, only the write SHALL be accepted; o_empty deasserts the next cycle.
REQ-022 Written data SHALL be readable at o_rd_data one cycle after the accepting edge.
REQ-023 Pointers SHALL wrap silently at Depth; ordering across wrap SHALL be preserved.
REQ-024 i_clr SHALL take priority over i_wr_en and i_rd_en in the same cycle: it zeroes pointers and count and clears the sticky flags, and it leaves memory contents unmodified.

Reset
REQ-025 While i_rstn is low, pointers and o_count SHALL be 0, o_empty and o_almost_empty SHALL be 1, o_full, o_almost_full, o_overflow and o_underflow SHALL be 0, and no write SHALL occur.
REQ-026 Reset asserted mid-operation SHALL discard all queued entries; the memory array is not reset.

Configuration
REQ-027 With FIFO_SYNC_ERR_EN defined, o_overflow SHALL set on any cycle with i_wr_en && o_full, and o_underflow SHALL set on any cycle with i_rd_en && o_empty; both hold until reset or i_clr.
REQ-028 Without FIFO_SYNC_ERR_EN, o_overflow and o_underflow SHALL be tied to 0 and the sticky logic SHALL be absent; the ports remain.

Structure
REQ-029 Shared package fifo_pkg SHALL hold the default-threshold constants and the address/count width helper used by all FIFO variants.
REQ-030 Storage SHALL be the sub-module fifo_mem (Depth x Width, synchronous write, asynchronous read, no reset); the control logic stays in fifo_sync.

Verification (Depth=8, Width=8, AlmostFull=6, AlmostEmpty=2)
REQ-031 After reset, write 0x11..0x88 (8 writes) -> o_full=1 with o_count=8; reads return 0x11..0x88 in order; o_empty=1 after the 8th read.
REQ-032 Full, then a 9th write of 0xFF -> rejected, o_count stays 8, o_overflow=1 (macro defined) or 0 (undefined); next read returns 0x11.
REQ-033 Count 8, i_wr_en=i_rd_en=1 -> o_count=7, o_full=0; at count 0 with both high -> o_count=1, and o_rd_data equals the written word next cycle.
REQ-034 Sixteen writes interleaved with reads across pointer wrap, keeping count at 3 -> in-order data; o_almost_empty toggles at count<=2 and o_almost_full at >=6.
REQ-035 Count 5 with i_clr=1 and i_wr_en=1 -> o_count=0, o_empty=1, sticky flags 0; read while empty -> o_underflow=1 (macro defined).
REQ-036 i_rstn pulsed low mid-burst at count 4 -> flags and count return to reset values asynchronously; the first post-reset write of 0xA5 reads back 0xA5.

Source files
------------

// File: rtl/fifo_pkg.sv
// fifo_pkg -- constants and helpers shared by the FIFO variants.
//
// Contents:
//   DEF_ALMOST_FULL_MARGIN : default distance below Depth at which the
//                            almost-full flag asserts (AlmostFull = Depth - 2)
//   DEF_ALMOST_EMPTY       : default occupancy at or below which the
//                            almost-empty flag asserts
//   fifo_aw()              : address width for a given depth; the occupancy
//                            counter is one bit wider so it can hold Depth
package fifo_pkg;

  localparam int DEF_ALMOST_FULL_MARGIN = 2;
  localparam int DEF_ALMOST_EMPTY       = 2;

  function automatic int fifo_aw(input int depth);
    return $clog2(depth);
  endfunction

endpackage : fifo_pkg

// File: rtl/fifo_mem.sv
// fifo_mem -- Depth x Width storage array for the FIFO family.
//
// Synchronous write and asynchronous (combinational) read. The array has no
// reset, so its contents survive both reset and flush.
//
// Ports:
//   i_clk     : clock, writes occur on its rising edge
//   i_wr_en   : write strobe (already qualified by the controller)
//   i_wr_addr : write address
//   i_wr_data : write data
//   i_rd_addr : read address
//   o_rd_data : entry at i_rd_addr, combinational
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int Depth = 8,
  parameter int Width = 8
) (
  input  logic                       i_clk,
  input  logic                       i_wr_en,
  input  logic [fifo_aw(Depth)-1:0]  i_wr_addr,
  input  logic [Width-1:0]           i_wr_data,
  input  logic [fifo_aw(Depth)-1:0]  i_rd_addr,
  output logic [Width-1:0]           o_rd_data
);

  logic [Width-1:0] mem_q [Depth];

  // Storage write port; deliberately no reset so the array maps onto RAM.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      mem_q[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = mem_q[i_rd_addr];

endmodule : fifo_mem

// File: rtl/fifo_sync.sv
// fifo_sync -- single-clock show-ahead FIFO controller.
//
// Depth must be a power of two and at least 2, so the pointers wrap simply by
// overflowing their natural width. Storage lives in fifo_mem.
//
// Optional build macro FIFO_SYNC_ERR_EN: when defined, o_overflow and
// o_underflow are sticky error flags; when undefined they are tied low and the
// sticky logic is not built.
//
// Ports:
//   i_clk          : clock, rising edge
//   i_rstn         : asynchronous active-low reset
//   i_clr          : synchronous flush, overrides read and write
//   i_wr_en        : write request
//   i_wr_data      : write data
//   i_rd_en        : read request (pop)
//   o_rd_data      : head-of-queue data, valid whenever not empty
//   o_full         : count == Depth
//   o_empty        : count == 0
//   o_almost_full  : count >= AlmostFull
//   o_almost_empty : count <= AlmostEmpty
//   o_count        : occupancy, 0..Depth
//   o_overflow     : sticky, write attempted while full
//   o_underflow    : sticky, read attempted while empty
module fifo_sync
  import fifo_pkg::*;
#(
  parameter int Depth       = 8,
  parameter int Width       = 8,
  parameter int AlmostFull  = Depth - DEF_ALMOST_FULL_MARGIN,
  parameter int AlmostEmpty = DEF_ALMOST_EMPTY
) (
  input  logic                     i_clk,
  input  logic                     i_rstn,
  input  logic                     i_clr,
  input  logic                     i_wr_en,
  input  logic [Width-1:0]         i_wr_data,
  input  logic                     i_rd_en,
  output logic [Width-1:0]         o_rd_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic                     o_almost_full,
  output logic                     o_almost_empty,
  output logic [fifo_aw(Depth):0]  o_count,
  output logic                     o_overflow,
  output logic                     o_underflow
);

  localparam int AW = fifo_aw(Depth);

  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
  localparam logic [AW:0]   CNT_DEPTH = (AW+1)'(Depth);
  localparam logic [AW:0]   CNT_AF    = (AW+1)'(AlmostFull);
  localparam logic [AW:0]   CNT_AE    = (AW+1)'(AlmostEmpty);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q,  count_d;
  logic          wr_accept;
  logic          rd_accept;

  // Flags are decoded from the registered count only.
  assign o_full         = (count_q == CNT_DEPTH);
  assign o_empty        = (count_q == '0);
  assign o_almost_full  = (count_q >= CNT_AF);
  assign o_almost_empty = (count_q <= CNT_AE);
  assign o_count        = count_q;

  // A flush swallows both requests. Gating the write with i_rstn keeps the
  // array untouched while reset is held.
  assign wr_accept = i_wr_en && !o_full  && !i_clr && i_rstn;
  assign rd_accept = i_rd_en && !o_empty && !i_clr;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (i_clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_accept) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (rd_accept) rd_ptr_d = rd_ptr_q + PTR_ONE;
      case ({wr_accept, rd_accept})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

`ifdef FIFO_SYNC_ERR_EN
  logic ovf_q, ovf_d;
  logic unf_q, unf_d;

  // Error flags look at the raw requests against the registered status, so a
  // rejected request is recorded even when the other side was accepted.
  always_comb begin
    ovf_d = ovf_q;
    unf_d = unf_q;
    if (i_clr) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end else begin
      if (i_wr_en && o_full)  ovf_d = 1'b1;
      if (i_rd_en && o_empty) unf_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign o_overflow  = ovf_q;
  assign o_underflow = unf_q;
`else
  assign o_overflow  = 1'b0;
  assign o_underflow = 1'b0;
`endif

  fifo_mem #(
    .Depth (Depth),
    .Width (Width)
  ) u_mem (
    .i_clk     (i_clk),
    .i_wr_en   (wr_accept),
    .i_wr_addr (wr_ptr_q),
    .i_wr_data (i_wr_data),
    .i_rd_addr (rd_ptr_q),
    .o_rd_data (o_rd_data)
  );

endmodule : fifo_sync

// File: tb/tb_fifo_sync.sv
// tb_fifo_sync -- directed self-checking bench for fifo_sync
// (Depth=8, Width=8, AlmostFull=6, AlmostEmpty=2).
module tb_fifo_sync;

`ifdef FIFO_SYNC_ERR_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic       clk;
  logic       rstn;
  logic       clr;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic [3:0] count;
  logic       overflow;
  logic       underflow;

  int total = 0;
  int bad   = 0;

  fifo_sync #(
    .Depth       (8),
    .Width       (8),
    .AlmostFull  (6),
    .AlmostEmpty (2)
  ) dut (
    .i_clk          (clk),
    .i_rstn         (rstn),
    .i_clr          (clr),
    .i_wr_en        (wr_en),
    .i_wr_data      (wr_data),
    .i_rd_en        (rd_en),
    .o_rd_data      (rd_data),
    .o_full         (full),
    .o_empty        (empty),
    .o_almost_full  (almost_full),
    .o_almost_empty (almost_empty),
    .o_count        (count),
    .o_overflow     (overflow),
    .o_underflow    (underflow)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of requests on the falling edge, let the rising edge take
  // them, then drop the requests 1 unit later so checks see settled state.
  task automatic applyStimulus(input logic wr, input logic [7:0] data,
                               input logic rd, input logic cl);
    @(negedge clk);
    wr_en   = wr;
    wr_data = data;
    rd_en   = rd;
    clr     = cl;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    clr   = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Check every status flag and the count against one expected occupancy.
  task automatic checkStatus(input string tag, input int exp_count);
    checkOutput({tag, ".count"}, 32'(count), 32'(exp_count));
    checkOutput({tag, ".full"},  32'(full),  32'(exp_count == 8));
    checkOutput({tag, ".empty"}, 32'(empty), 32'(exp_count == 0));
    checkOutput({tag, ".afull"}, 32'(almost_full),  32'(exp_count >= 6));
    checkOutput({tag, ".aempty"},32'(almost_empty), 32'(exp_count <= 2));
  endtask

  initial begin
    logic [7:0] exp_data;

    rstn    = 1'b0;
    clr     = 1'b0;
    wr_en   = 1'b0;
    wr_data = 8'h00;
    rd_en   = 1'b0;

    // Reset state while reset is still held.
    repeat (3) @(posedge clk);
    #1;
    checkStatus("reset", 0);
    checkOutput("reset.ovf", 32'(overflow), 32'h0);
    checkOutput("reset.unf", 32'(underflow), 32'h0);
    @(negedge clk);
    rstn = 1'b1;

    // Fill with 0x11..0x88.
    for (int i = 1; i <= 8; i++) begin
      exp_data = 8'(i * 8'h11);
      applyStimulus(1'b1, exp_data, 1'b0, 1'b0);
      checkOutput("fill.count", 32'(count), 32'(i));
      checkOutput("fill.head", 32'(rd_data), 32'h11);
    end
    checkStatus("full", 8);

    // Ninth write is refused.
    applyStimulus(1'b1, 8'hFF, 1'b0, 1'b0);
    checkStatus("ovf_wr", 8);
    checkOutput("ovf_wr.ovf", 32'(overflow), 32'(ERR_EN));
    checkOutput("ovf_wr.head", 32'(rd_data), 32'h11);

    // Full with both requests: only the read goes through.
    applyStimulus(1'b1, 8'h99, 1'b1, 1'b0);
    checkStatus("full_both", 7);
    checkOutput("full_both.head", 32'(rd_data), 32'h22);

    // Drain 0x22..0x88 in order.
    for (int i = 2; i <= 8; i++) begin
      exp_data = 8'(i * 8'h11);
      checkOutput("drain.data", 32'(rd_data), 32'(exp_data));
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      checkOutput("drain.count", 32'(count), 32'(8 - i));
    end
    checkStatus("drained", 0);

    // Empty with both requests: only the write goes through.
    applyStimulus(1'b1, 8'h3C, 1'b1, 1'b0);
    checkStatus("empty_both", 1);
    checkOutput("empty_both.data", 32'(rd_data), 32'h3C);
    checkOutput("empty_both.unf", 32'(underflow), 32'(ERR_EN));
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkStatus("empty_both_pop", 0);

    // Prime three entries, then stream across the pointer wrap at count 3.
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 8'(8'hB0 + k), 1'b0, 1'b0);
      checkStatus("prime", k + 1);
    end
    for (int j = 0; j < 13; j++) begin
      checkOutput("wrap.data", 32'(rd_data), 32'(8'hB0 + j));
      applyStimulus(1'b1, 8'(8'hB3 + j), 1'b1, 1'b0);
      checkOutput("wrap.count", 32'(count), 32'd3);
    end
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 8'(8'hC0 + k), 1'b0, 1'b0);
      checkStatus("rise", 4 + k);
    end
    checkOutput("wrap.head", 32'(rd_data), 32'hBD);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkStatus("fall", 5);
    checkOutput("fall.head", 32'(rd_data), 32'hBE);

    // Flush beats a simultaneous write.
    applyStimulus(1'b1, 8'hEE, 1'b0, 1'b1);
    checkStatus("clr", 0);
    checkOutput("clr.ovf", 32'(overflow), 32'h0);
    checkOutput("clr.unf", 32'(underflow), 32'h0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkStatus("unf_rd", 0);
    checkOutput("unf_rd.unf", 32'(underflow), 32'(ERR_EN));

    // Reset pulsed mid-burst at count 4.
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 8'(8'h41 + k), 1'b0, 1'b0);
    end
    checkStatus("pre_rst", 4);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_data = 8'h5A;
    rstn    = 1'b0;
    #1;
    checkStatus("async_rst", 0);
    checkOutput("async_rst.unf", 32'(underflow), 32'h0);
    checkOutput("async_rst.ovf", 32'(overflow), 32'h0);
    @(posedge clk);
    #1;
    checkStatus("rst_held", 0);
    @(negedge clk);
    wr_en = 1'b0;
    rstn  = 1'b1;
    applyStimulus(1'b1, 8'hA5, 1'b0, 1'b0);
    checkStatus("post_rst", 1);
    checkOutput("post_rst.data", 32'(rd_data), 32'hA5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_fifo_sync
